// File: rtl/snow64_long_div_u16_by_u8_requester_pkg.sv
// snow64_long_div_u16_by_u8_requester_pkg: shared widths, latency, port structs and FSM states for the u16/u8 divider requester
package snow64_long_div_u16_by_u8_requester_pkg;
  localparam int WIDTH__SNOW64_LONG_DIV_U16_BY_U8__IN_A = 16;
  localparam int WIDTH__SNOW64_LONG_DIV_U16_BY_U8__IN_B = 8;
  localparam int WIDTH__SNOW64_LONG_DIV_U16_BY_U8__OUT_DATA = 16;
  localparam int WIDTH__REQUESTER_TAG = 4;
  localparam int LATENCY__SNOW64_LONG_DIV_U16_BY_U8 = 7;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} st_requester_t;
  typedef struct packed {
    logic req_valid;
    logic [WIDTH__SNOW64_LONG_DIV_U16_BY_U8__IN_A-1:0] a;
    logic [WIDTH__SNOW64_LONG_DIV_U16_BY_U8__IN_B-1:0] b;
    logic [WIDTH__REQUESTER_TAG-1:0] tag;
  } port_in_long_div_u16_by_u8_requester_t;
  typedef struct packed {
    logic rsp_valid;
    logic [WIDTH__SNOW64_LONG_DIV_U16_BY_U8__OUT_DATA-1:0] quotient;
    logic [WIDTH__SNOW64_LONG_DIV_U16_BY_U8__IN_B-1:0] remainder;
    logic [WIDTH__REQUESTER_TAG-1:0] tag;
    logic div_by_zero;
    logic timeout;
  } port_out_long_div_u16_by_u8_requester_t;
endpackage

// File: rtl/snow64_long_div_u16_by_u8_requester.sv
// snow64_long_div_u16_by_u8_requester: tagged valid/ready front end driving the radix-8 u16/u8 long divider
// req_*: upstream request handshake (a, b, tag); div_*: divider command and completion port;
// rsp_*: downstream response with quotient, remainder, echoed tag, div-by-zero and timeout flags.
module snow64_long_div_u16_by_u8_requester
  import snow64_long_div_u16_by_u8_requester_pkg::*;
#(
  parameter int TAG_WIDTH = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  output logic req_ready,
  input  logic [WIDTH__SNOW64_LONG_DIV_U16_BY_U8__IN_A-1:0] req_a,
  input  logic [WIDTH__SNOW64_LONG_DIV_U16_BY_U8__IN_B-1:0] req_b,
  input  logic [TAG_WIDTH-1:0] req_tag,
  output logic div_start,
  output logic [WIDTH__SNOW64_LONG_DIV_U16_BY_U8__IN_A-1:0] div_a,
  output logic [WIDTH__SNOW64_LONG_DIV_U16_BY_U8__IN_B-1:0] div_b,
  input  logic div_can_accept_cmd,
  input  logic div_data_valid,
  input  logic [WIDTH__SNOW64_LONG_DIV_U16_BY_U8__OUT_DATA-1:0] div_data,
  output logic rsp_valid,
  input  logic rsp_ready,
  output logic [WIDTH__SNOW64_LONG_DIV_U16_BY_U8__OUT_DATA-1:0] rsp_quotient,
  output logic [WIDTH__SNOW64_LONG_DIV_U16_BY_U8__IN_B-1:0] rsp_remainder,
  output logic [TAG_WIDTH-1:0] rsp_tag,
  output logic rsp_div_by_zero,
  output logic rsp_timeout
);
  localparam int WB = WIDTH__SNOW64_LONG_DIV_U16_BY_U8__IN_B;
  localparam int WP = WIDTH__SNOW64_LONG_DIV_U16_BY_U8__IN_A + WB;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  st_requester_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [TAG_WIDTH-1:0] tag_q;
  logic dbz_q;
  logic timeout_hit;
  logic [WB-1:0] rem;
  assign req_ready = state == ST_IDLE;
  // div_a/div_b double as the captured request registers
  assign div_start = state == ST_ISSUE && div_can_accept_cmd;
  assign timeout_hit = cnt == CW'(TIMEOUT_CYCLES - 1);
  // low byte of a - q*b; a zero divisor would otherwise leak a back as remainder
  assign rem = dbz_q ? '0 : WB'(WP'(div_a) - WP'(div_data) * WP'(div_b));
  always_comb begin
    state_nx = state == ST_IDLE  ? (req_valid ? ST_ISSUE : ST_IDLE)
             : state == ST_ISSUE ? (div_can_accept_cmd ? ST_WAIT : ST_ISSUE)
             : state == ST_WAIT  ? ((div_data_valid || timeout_hit) ? ST_RESP : ST_WAIT)
             : (rsp_ready ? ST_IDLE : ST_RESP);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt <= '0;
      div_a <= '0;
      div_b <= '0;
      tag_q <= '0;
      dbz_q <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_quotient <= '0;
      rsp_remainder <= '0;
      rsp_tag <= '0;
      rsp_div_by_zero <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state <= state_nx;
      if (req_ready && req_valid) begin
        div_a <= req_a;
        div_b <= req_b;
        tag_q <= req_tag;
        dbz_q <= req_b == '0;
      end
      if (state == ST_WAIT) begin
        cnt <= state_nx == ST_WAIT ? cnt + 1'b1 : '0;
        if (state_nx == ST_RESP) begin
          rsp_valid <= 1'b1;
          rsp_quotient <= div_data_valid ? div_data : '0;
          rsp_remainder <= div_data_valid ? rem : '0;
          rsp_tag <= tag_q;
          rsp_div_by_zero <= dbz_q;
          rsp_timeout <= !div_data_valid;
        end
      end
      if (state == ST_RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end
endmodule
